// File: rtl/ne_decoder_pkg.sv
// Shared definitions for the NE decoder input loader: read FSM states and
// helpers for splitting an input beat index into lane and address.
package ne_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_LOAD = 2'd2
    } load_state_e;

    // Index width for a counter over n values, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Input beats making up one codeword
    function automatic int beats_per_cw(input int nb, input int loadcount);
        return nb * loadcount;
    endfunction

    // Sub-memory lane that receives input beat number 'beat'
    function automatic int lane_of(input int beat, input int nb);
        return beat % nb;
    endfunction

    // Load address that receives input beat number 'beat'
    function automatic int addr_of(input int beat, input int nb);
        return beat / nb;
    endfunction

endpackage

// File: rtl/ne_codeword_bank.sv
// One codeword bank: NB independent lanes of 2**AW x DW storage. A write goes
// to a single lane; a read returns all lanes at one address, one cycle later.
module ne_codeword_bank
    import ne_decoder_pkg::*;
#(
    parameter int DW = 384,
    parameter int NB = 16,
    parameter int AW = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en_i,
    input  logic [idx_width(NB)-1:0]    wr_lane_i,
    input  logic [AW-1:0]               wr_addr_i,
    input  logic [DW-1:0]               wr_data_i,
    input  logic                        rd_en_i,
    input  logic [AW-1:0]               rd_addr_i,
    output logic [NB*DW-1:0]            rd_data_o
);

    localparam int LANE_W = idx_width(NB);
    localparam int DEPTH  = 2 ** AW;

    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] rd_q;

        // Lane write: only the lane selected by the beat index takes the data
        always_ff @(posedge clk) begin
            if (wr_en_i && (wr_lane_i == LANE_W'(gi))) begin
                mem[wr_addr_i] <= wr_data_i;
            end
        end

        // Registered read; the output register holds between reads
        always_ff @(posedge clk) begin
            if (!rst) begin
                rd_q <= '0;
            end else if (rd_en_i) begin
                rd_q <= mem[rd_addr_i];
            end
        end

        assign rd_data_o[gi*DW +: DW] = rd_q;
    end

endmodule

// File: rtl/ne_pingpong_input_loader.sv
// Ping-pong input loader for the NE LDPC decoder. Input beats fill one bank
// while the other bank is streamed into the decoder memories; a decodestart
// pulse follows each complete load and frees the bank for new input.
module ne_pingpong_input_loader
    import ne_decoder_pkg::*;
#(
    parameter int W            = 12,
    parameter int CW           = 32,
    parameter int NB           = 16,
    parameter int LOADCOUNT    = 17,
    parameter int ADDRESSWIDTH = 5,
    parameter int SYNC_WAIT    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CW*W-1:0]         in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    decoder_ready,
    output logic                    load_en_out,
    output logic [ADDRESSWIDTH-1:0] load_addr,
    output logic [NB*CW*W-1:0]      load_data,
    output logic                    load_bank,
    output logic                    decodestart,
    output logic [1:0]              bank_full
);

    localparam int DW     = CW * W;
    localparam int BEATS  = beats_per_cw(NB, LOADCOUNT);
    localparam int BCW    = idx_width(BEATS);
    localparam int LANE_W = idx_width(NB);
    localparam int LC_W   = idx_width(LOADCOUNT);
    localparam int SW_W   = idx_width(SYNC_WAIT);
    localparam int CNT_W  = (LC_W > SW_W) ? LC_W : SW_W;

    load_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BCW-1:0]          beat_q, beat_d;
    logic                    wr_bank_q, wr_bank_d;
    logic                    rd_bank_q, rd_bank_d;
    logic [1:0]              bank_full_q, bank_full_d;
    logic                    load_en_q;
    logic [ADDRESSWIDTH-1:0] load_addr_q;
    logic                    load_bank_q;
    logic                    decodestart_q, decodestart_d;

    logic                    accept;
    logic [LANE_W-1:0]       wr_lane;
    logic [ADDRESSWIDTH-1:0] wr_addr;
    logic                    rd_en;
    logic [ADDRESSWIDTH-1:0] raddr;
    logic [NB*DW-1:0]        bank_rd [2];

    assign in_ready = !bank_full_q[wr_bank_q];
    assign accept   = in_valid && in_ready;
    assign wr_lane  = LANE_W'(lane_of(int'(beat_q), NB));
    assign wr_addr  = ADDRESSWIDTH'(addr_of(int'(beat_q), NB));

    // Write side: beat counting, bank filling and freeing, bank pointers
    always_comb begin
        beat_d      = beat_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        bank_full_d = bank_full_q;
        if (accept) begin
            if (beat_q == BCW'(BEATS - 1)) begin
                beat_d                 = '0;
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = ~wr_bank_q;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
        // The bank being freed is full, so it never collides with the write above
        if (decodestart_q) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end
    end

    // Read FSM: wait for a full bank and an idle decoder, settle, then stream
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_en   = 1'b0;
        raddr   = '0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // Hold off while the previous load is still retiring its bank
                if (bank_full_q[rd_bank_q] && decoder_ready && !load_en_q && !decodestart_q) begin
                    state_d = (SYNC_WAIT == 0) ? ST_LOAD : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(SYNC_WAIT - 1)) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LOAD: begin
                rd_en = 1'b1;
                raddr = ADDRESSWIDTH'(cnt_q);
                if (cnt_q == CNT_W'(LOADCOUNT - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The pulse follows the cycle that presented the last load word
    assign decodestart_d = load_en_q && (load_addr_q == ADDRESSWIDTH'(LOADCOUNT - 1));

    // State registers; load address/bank hold outside a load so load_data stays stable
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            beat_q        <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            bank_full_q   <= '0;
            load_en_q     <= 1'b0;
            load_addr_q   <= '0;
            load_bank_q   <= 1'b0;
            decodestart_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            beat_q        <= beat_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            bank_full_q   <= bank_full_d;
            load_en_q     <= rd_en;
            decodestart_q <= decodestart_d;
            if (rd_en) begin
                load_addr_q <= raddr;
                load_bank_q <= rd_bank_q;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        ne_codeword_bank #(
            .DW (DW),
            .NB (NB),
            .AW (ADDRESSWIDTH)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (accept && (wr_bank_q == 1'(gi))),
            .wr_lane_i (wr_lane),
            .wr_addr_i (wr_addr),
            .wr_data_i (in_data),
            .rd_en_i   (rd_en && (rd_bank_q == 1'(gi))),
            .rd_addr_i (raddr),
            .rd_data_o (bank_rd[gi])
        );
    end

    assign load_data   = bank_rd[load_bank_q];
    assign load_en_out = load_en_q;
    assign load_addr   = load_addr_q;
    assign load_bank   = load_bank_q;
    assign decodestart = decodestart_q;
    assign bank_full   = bank_full_q;

endmodule

// File: tb/tb_ne_pingpong_input_loader.sv
// Bench for ne_pingpong_input_loader: scenario table plus hand sequences on the
// default configuration, and a latency/data sequence on a small configuration.
module tb_ne_pingpong_input_loader;

    localparam int W = 12, CW = 32, NB = 16, LC = 17, AW = 5, SW = 4;
    localparam int DW = W * CW;
    localparam int BEATS = NB * LC;
    localparam int S_DW = 16, S_NB = 4, S_LC = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              rst;
    logic [DW-1:0]     in_data;
    logic              in_valid, in_ready, decoder_ready;
    logic              load_en_out, load_bank, decodestart;
    logic [AW-1:0]     load_addr;
    logic [NB*DW-1:0]  load_data;
    logic [1:0]        bank_full;

    logic [S_DW-1:0]      s_in_data;
    logic                 s_in_valid, s_in_ready, s_decoder_ready;
    logic                 s_load_en_out, s_load_bank, s_decodestart;
    logic [2:0]           s_load_addr;
    logic [S_NB*S_DW-1:0] s_load_data;
    logic [1:0]           s_bank_full;

    ne_pingpong_input_loader #(
        .W(W), .CW(CW), .NB(NB), .LOADCOUNT(LC), .ADDRESSWIDTH(AW), .SYNC_WAIT(SW)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .decoder_ready(decoder_ready), .load_en_out(load_en_out), .load_addr(load_addr),
        .load_data(load_data), .load_bank(load_bank), .decodestart(decodestart),
        .bank_full(bank_full)
    );

    ne_pingpong_input_loader #(
        .W(8), .CW(2), .NB(S_NB), .LOADCOUNT(S_LC), .ADDRESSWIDTH(3), .SYNC_WAIT(0)
    ) dut_small (
        .clk(clk), .rst(rst), .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .decoder_ready(s_decoder_ready), .load_en_out(s_load_en_out), .load_addr(s_load_addr),
        .load_data(s_load_data), .load_bank(s_load_bank), .decodestart(s_decodestart),
        .bank_full(s_bank_full)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_word(input string nm, input logic [NB*DW-1:0] act, input logic [NB*DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            for (int j = 0; j < NB; j++) begin
                if (act[j*DW +: DW] !== exp[j*DW +: DW]) begin
                    $display("FAIL %s lane %0d: got %0h expected %0h", nm, j,
                             act[j*DW +: DW], exp[j*DW +: DW]);
                    break;
                end
            end
        end
    endtask

    // ---------------- reference model ----------------
    // Codewords are kept as plain beat lists: completed codewords wait in
    // full_q (in arrival order) until their decodestart; a load word at
    // address a is simply beats NB*a .. NB*a+NB-1 of the oldest codeword.
    typedef logic [DW-1:0] beat_t;
    beat_t            part_q[$];
    beat_t            full_q[$];
    int               load_idx = 0;
    logic             exp_bank = 1'b0;
    int               ndone = 0;
    bit               mon_en = 1'b0;
    logic [NB*DW-1:0] exp_word;

    always @(negedge clk) begin
        if (mon_en) begin
            // Input is refused exactly while two codewords are held
            chk("in_ready", in_ready, (full_q.size() < 2 * BEATS));
            chk("bank_full_count", $countones(bank_full), full_q.size() / BEATS);
            if (load_en_out === 1'b1) begin
                if (full_q.size() < BEATS || load_idx >= LC) begin
                    total++;
                    bad++;
                    $display("FAIL load_unexpected: addr=%0d idx=%0d held_beats=%0d",
                             load_addr, load_idx, full_q.size());
                end else begin
                    for (int j = 0; j < NB; j++) exp_word[j*DW +: DW] = full_q[NB*load_idx + j];
                    chk("load_addr", load_addr, load_idx);
                    chk("load_bank", load_bank, exp_bank);
                    chk_word("load_data", load_data, exp_word);
                    load_idx++;
                end
            end
            if (decodestart === 1'b1) begin
                chk("words_before_decodestart", load_idx, LC);
                $display("codeword %0d loaded from bank %0d", ndone, exp_bank);
                for (int k = 0; k < BEATS && full_q.size() > 0; k++) void'(full_q.pop_front());
                load_idx = 0;
                exp_bank = ~exp_bank;
                ndone++;
            end
            if (rst === 1'b0) begin
                part_q.delete();
                full_q.delete();
                load_idx = 0;
                exp_bank = 1'b0;
            end else if (in_valid === 1'b1 && in_ready === 1'b1) begin
                part_q.push_back(in_data);
                if (part_q.size() == BEATS) begin
                    foreach (part_q[k]) full_q.push_back(part_q[k]);
                    part_q.delete();
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int bidx = 0;
    int last_acc_cyc = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_load_en_out"}, load_en_out, 1'b0);
        chk({tag, "_load_addr"}, load_addr, 0);
        chk({tag, "_load_bank"}, load_bank, 1'b0);
        chk({tag, "_decodestart"}, decodestart, 1'b0);
        chk({tag, "_bank_full"}, bank_full, 2'b00);
        chk_word({tag, "_load_data"}, load_data, '0);
    endtask

    task automatic do_reset(input int ncyc, input string tag);
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (ncyc) tick();
        check_reset_vals(tag);
        rst = 1'b1;
        bidx = 0;
    endtask

    // Push n accepted beats; mode 0 sends the beat index, mode 1 random data
    task automatic feed(input int n, input int bubble, input int mode);
        int sent = 0;
        int guard = 0;
        bit acc;
        while (sent < n && guard < 4 * n + 400) begin
            in_valid = ($urandom_range(99) >= bubble);
            if (mode == 0) in_data = DW'(bidx % BEATS);
            else for (int k = 0; k < DW / 32; k++) in_data[k*32 +: 32] = $urandom();
            acc = in_valid && in_ready;
            if (acc) last_acc_cyc = cyc;
            tick();
            if (acc) begin
                sent++;
                bidx++;
            end
            guard++;
        end
        in_valid = 1'b0;
        if (sent < n) begin
            total++;
            bad++;
            $display("FAIL feed_timeout: sent=%0d wanted=%0d", sent, n);
        end
    endtask

    task automatic wait_done(input int target, input int limit);
        int c = 0;
        while (ndone < target && c < limit) begin
            tick();
            c++;
        end
        chk("done_count", ndone, target);
    endtask

    typedef struct {
        int         ncw;
        int         bubble;
        bit         ready_low;
        int         mode;
        logic [1:0] exp_full;
        logic       exp_rdy;
    } scen_t;

    scen_t tbl[5];

    initial begin
        watchdog_guard();
    end

    task automatic watchdog_guard();
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    endtask

    initial begin
        int d0, first, ds, nload, a;
        bit found;

        in_valid = 1'b0;
        in_data = '0;
        decoder_ready = 1'b0;
        s_in_valid = 1'b0;
        s_in_data = '0;
        s_decoder_ready = 1'b1;

        // Scenario table: codewords, bubble %, decoder held off during the fill,
        // data mode, expected bank_full / in_ready (after stall, or at the end)
        tbl[0] = '{ncw: 1, bubble: 0,  ready_low: 1'b0, mode: 0, exp_full: 2'b00, exp_rdy: 1'b1};
        tbl[1] = '{ncw: 1, bubble: 50, ready_low: 1'b0, mode: 0, exp_full: 2'b00, exp_rdy: 1'b1};
        tbl[2] = '{ncw: 3, bubble: 0,  ready_low: 1'b1, mode: 1, exp_full: 2'b11, exp_rdy: 1'b0};
        tbl[3] = '{ncw: 1, bubble: 20, ready_low: 1'b1, mode: 1, exp_full: 2'b01, exp_rdy: 1'b1};
        tbl[4] = '{ncw: 4, bubble: 30, ready_low: 1'b0, mode: 1, exp_full: 2'b00, exp_rdy: 1'b1};

        do_reset(2, "init");
        mon_en = 1'b1;

        // Single codeword, exact latency and addressing
        decoder_ready = 1'b1;
        feed(BEATS, 0, 0);
        first = -1; ds = -1; nload = 0;
        for (int k = 0; k < 60; k++) begin
            if (load_en_out) begin
                nload++;
                if (first < 0) first = cyc;
                if (load_addr == 5) chk("t1_lane3_addr5", load_data[3*DW +: DW], 16 * 5 + 3);
            end
            if (decodestart) begin
                ds = cyc;
                break;
            end
            tick();
        end
        chk("t1_first_load_latency", first - last_acc_cyc, SW + 3);
        chk("t1_decodestart_latency", ds - last_acc_cyc, SW + 3 + LC);
        chk("t1_load_words", nload, LC);

        // Table-driven scenarios
        foreach (tbl[i]) begin
            do_reset(2, "scen_rst");
            d0 = ndone;
            decoder_ready = !tbl[i].ready_low;
            if (tbl[i].ready_low) begin
                a = (tbl[i].ncw < 2) ? tbl[i].ncw : 2;
                feed(a * BEATS, tbl[i].bubble, tbl[i].mode);
                chk("stall_bank_full", bank_full, tbl[i].exp_full);
                chk("stall_in_ready", in_ready, tbl[i].exp_rdy);
                nload = 0;
                repeat (20) begin
                    if (load_en_out) nload++;
                    tick();
                end
                chk("stall_no_load", nload, 0);
                decoder_ready = 1'b1;
                feed((tbl[i].ncw - a) * BEATS, tbl[i].bubble, tbl[i].mode);
            end else begin
                feed(tbl[i].ncw * BEATS, tbl[i].bubble, tbl[i].mode);
            end
            wait_done(d0 + tbl[i].ncw, 600);
            tick();
            tick();
            if (!tbl[i].ready_low) chk("end_bank_full", bank_full, tbl[i].exp_full);
            $display("scenario %0d: codewords=%0d loaded=%0d", i, tbl[i].ncw, ndone - d0);
        end

        // Reset in the middle of writing, then a clean codeword
        do_reset(2, "t4a_pre");
        decoder_ready = 1'b1;
        feed(100, 0, 1);
        rst = 1'b0;
        tick();
        check_reset_vals("t4a");
        rst = 1'b1;
        d0 = ndone;
        feed(BEATS, 0, 1);
        wait_done(d0 + 1, 200);

        // Reset in the middle of loading: no decodestart, then a clean codeword
        feed(BEATS, 0, 1);
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (load_en_out && load_addr == 8) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("t4b_reached_addr8", found, 1'b1);
        rst = 1'b0;
        tick();
        check_reset_vals("t4b");
        rst = 1'b1;
        nload = 0;
        repeat (40) begin
            if (decodestart) nload++;
            tick();
        end
        chk("t4b_no_decodestart", nload, 0);
        d0 = ndone;
        feed(BEATS, 0, 1);
        wait_done(d0 + 1, 200);

        // decoder_ready toggling after the grant is ignored
        d0 = ndone;
        decoder_ready = 1'b1;
        feed(BEATS, 0, 1);
        tick();
        nload = 0;
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (load_en_out) nload++;
            if (decodestart) begin
                found = 1'b1;
                break;
            end
            decoder_ready = 1'($urandom_range(1));
            tick();
        end
        chk("t6_decodestart_seen", found, 1'b1);
        chk("t6_load_words", nload, LC);
        decoder_ready = 1'b0;
        feed(BEATS, 0, 1);
        nload = 0;
        repeat (40) begin
            if (load_en_out) nload++;
            tick();
        end
        chk("t6_waits_for_ready", nload, 0);
        decoder_ready = 1'b1;
        wait_done(d0 + 2, 200);

        // Small configuration: NB=4, LOADCOUNT=5, no settle wait
        do_reset(2, "t5_rst");
        for (int b = 0; b < S_NB * S_LC; b++) begin
            s_in_valid = 1'b1;
            s_in_data = S_DW'(b);
            chk("t5_in_ready", s_in_ready, 1'b1);
            last_acc_cyc = cyc;
            tick();
        end
        s_in_valid = 1'b0;
        first = -1; ds = -1; a = 0;
        for (int k = 0; k < 30; k++) begin
            if (s_load_en_out) begin
                if (first < 0) first = cyc;
                chk("t5_load_addr", s_load_addr, a);
                chk("t5_load_bank", s_load_bank, 1'b0);
                for (int j = 0; j < S_NB; j++) chk("t5_lane", s_load_data[j*S_DW +: S_DW], S_NB * a + j);
                a++;
            end
            if (s_decodestart) begin
                ds = cyc;
                break;
            end
            tick();
        end
        chk("t5_first_load_latency", first - last_acc_cyc, 3);
        chk("t5_decodestart_latency", ds - last_acc_cyc, 3 + S_LC);
        chk("t5_load_words", a, S_LC);
        tick();
        chk("t5_bank_freed", s_bank_full, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
